iq_fm_discriminator: RTL and testbench

Sequential FM discriminator that consumes the decimated baseband I/Q stream produced by the IQ demodulation stage and outputs one signed audio sample per accepted I/Q pair. The output is proportional to the instantaneous phase step between consecutive samples. The block computes a conjugate product with the previous sample, then finds its angle with an iterative CORDIC in vectoring mode, one micro-rotation per clock. It sits between the IQ demodulator backend output and the audio path.

---
 rtl/iq_fm_discriminator.sv | 220 ++++++++++++++++++++++
 tb/tb_iq_fm_discriminator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_fm_discriminator.sv
// iq_fm_discriminator
// Sequential FM discriminator. For each accepted I/Q pair it forms the
// conjugate product with the previous pair and resolves its angle with an
// iterative vectoring CORDIC (one micro-rotation per clock). The audio output
// is the phase step, with full scale 2^OUT_WIDTH equal to 2*pi.
//
// Ports
//   clk_in      : clock, rising edge
//   RST_n       : asynchronous active-low reset
//   IN_VALID    : one-cycle strobe marking a new I/Q pair
//   I_IN, Q_IN  : signed baseband samples (IN_WIDTH)
//   AUDIO_OUT   : signed phase-step sample, held between updates (OUT_WIDTH)
//   AUDIO_VALID : one-cycle strobe for a new AUDIO_OUT
//   BUSY        : high while a sample is being processed
//   OVERRUN     : sticky, set when IN_VALID arrives while BUSY
module iq_fm_discriminator #(
    parameter int unsigned IN_WIDTH   = 12,
    parameter int unsigned OUT_WIDTH  = 12,
    parameter int unsigned PH_BITS    = 16,
    parameter int unsigned ITERATIONS = 14
) (
    input  logic                        clk_in,
    input  logic                        RST_n,
    input  logic                        IN_VALID,
    input  logic signed [IN_WIDTH-1:0]  I_IN,
    input  logic signed [IN_WIDTH-1:0]  Q_IN,
    output logic signed [OUT_WIDTH-1:0] AUDIO_OUT,
    output logic                        AUDIO_VALID,
    output logic                        BUSY,
    output logic                        OVERRUN
);

    localparam int unsigned PROD_W = 2 * IN_WIDTH;
    localparam int unsigned SUM_W  = 2 * IN_WIDTH + 1;
    localparam int unsigned XY_W   = 2 * IN_WIDTH + 3;
    localparam int unsigned K_W    = $clog2(ITERATIONS + 1);
    localparam int unsigned K_N    = 2 ** K_W;
    localparam int unsigned RND    = PH_BITS - OUT_WIDTH - 1;

    // atan(2^-k) as a fraction of a full turn, scaled by 2^32 (k = 0..31)
    localparam logic [31:0] ATAN32 [32] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // Round the 32-bit turn fraction to the PH_BITS angle format
    function automatic logic [PH_BITS-1:0] atan_round(input logic [4:0] idx);
        logic [32:0] t;
        t = {1'b0, ATAN32[idx]};
        if (PH_BITS < 32) begin
            t = t + (33'd1 << (31 - PH_BITS));
        end
        return PH_BITS'(t >> (32 - PH_BITS));
    endfunction

    typedef enum logic [1:0] {IDLE, MULT, ROTATE, DONE} state_t;

    state_t state, state_nxt;

    logic signed [IN_WIDTH-1:0]  cur_i, cur_q, prev_i, prev_q;
    logic signed [IN_WIDTH-1:0]  cur_i_nxt, cur_q_nxt, prev_i_nxt, prev_q_nxt;
    logic signed [XY_W-1:0]      x, y, x_nxt, y_nxt, x_sh, y_sh;
    logic [PH_BITS-1:0]          z, z_nxt;
    logic [K_W-1:0]              k, k_nxt;
    logic                        zero_flag, zero_nxt, primed, primed_nxt;
    logic signed [PROD_W-1:0]    p_ii, p_qq, p_qi, p_iq;
    logic signed [SUM_W-1:0]     re, im;
    logic [OUT_WIDTH-1:0]        z_top;
    logic signed [OUT_WIDTH-1:0] audio_nxt;
    logic                        audio_valid_nxt, busy_nxt, overrun_nxt;
    logic [PH_BITS-1:0]          atan_tab [K_N];

    // Per-iteration angle constants; entries past ITERATIONS are never reached
    for (genvar g = 0; g < K_N; g++) begin : g_atan
        assign atan_tab[g] = (g < ITERATIONS) ? atan_round(5'(g)) : '0;
    end

    // State register
    always_ff @(posedge clk_in or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the priming sample never leaves IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID && primed) state_nxt = MULT;
            MULT:    state_nxt = ROTATE;
            ROTATE:  if (k == K_W'(ITERATIONS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cur_i_nxt       = cur_i;
        cur_q_nxt       = cur_q;
        prev_i_nxt      = prev_i;
        prev_q_nxt      = prev_q;
        x_nxt           = x;
        y_nxt           = y;
        z_nxt           = z;
        k_nxt           = k;
        zero_nxt        = zero_flag;
        primed_nxt      = primed;
        audio_nxt       = AUDIO_OUT;
        audio_valid_nxt = 1'b0;
        busy_nxt        = (state_nxt != IDLE);
        overrun_nxt     = OVERRUN | (IN_VALID && (state != IDLE));

        // Conjugate product of current with previous sample, full precision
        p_ii  = PROD_W'(cur_i) * PROD_W'(prev_i);
        p_qq  = PROD_W'(cur_q) * PROD_W'(prev_q);
        p_qi  = PROD_W'(cur_q) * PROD_W'(prev_i);
        p_iq  = PROD_W'(cur_i) * PROD_W'(prev_q);
        re    = SUM_W'(p_ii) + SUM_W'(p_qq);
        im    = SUM_W'(p_qi) - SUM_W'(p_iq);

        x_sh  = x >>> k;
        y_sh  = y >>> k;
        z_top = z[PH_BITS-1 -: OUT_WIDTH];

        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    if (primed) begin
                        cur_i_nxt = I_IN;
                        cur_q_nxt = Q_IN;
                    end else begin
                        prev_i_nxt = I_IN;
                        prev_q_nxt = Q_IN;
                        primed_nxt = 1'b1;
                    end
                end
            end
            MULT: begin
                prev_i_nxt = cur_i;
                prev_q_nxt = cur_q;
                // Fold the left half-plane into the right by a pi pre-rotation
                if (re[SUM_W-1]) begin
                    x_nxt = -XY_W'(re);
                    y_nxt = -XY_W'(im);
                    z_nxt = PH_BITS'(1) << (PH_BITS - 1);
                end else begin
                    x_nxt = XY_W'(re);
                    y_nxt = XY_W'(im);
                    z_nxt = '0;
                end
                zero_nxt = (re == '0) && (im == '0);
                k_nxt    = '0;
            end
            ROTATE: begin
                // Drive y toward zero; z accumulates the rotated-out angle
                if (!y[XY_W-1]) begin
                    x_nxt = x + y_sh;
                    y_nxt = y - x_sh;
                    z_nxt = z + atan_tab[k];
                end else begin
                    x_nxt = x - y_sh;
                    y_nxt = y + x_sh;
                    z_nxt = z - atan_tab[k];
                end
                k_nxt = k + K_W'(1);
            end
            DONE: begin
                // Round half-up on the dropped bits; +pi wraps to the negative end
                audio_nxt       = zero_flag ? '0 : signed'(z_top + OUT_WIDTH'(z[RND]));
                audio_valid_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_in or negedge RST_n) begin
        if (!RST_n) begin
            cur_i       <= '0;
            cur_q       <= '0;
            prev_i      <= '0;
            prev_q      <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            k           <= '0;
            zero_flag   <= 1'b0;
            primed      <= 1'b0;
            AUDIO_OUT   <= '0;
            AUDIO_VALID <= 1'b0;
            BUSY        <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            cur_i       <= cur_i_nxt;
            cur_q       <= cur_q_nxt;
            prev_i      <= prev_i_nxt;
            prev_q      <= prev_q_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            z           <= z_nxt;
            k           <= k_nxt;
            zero_flag   <= zero_nxt;
            primed      <= primed_nxt;
            AUDIO_OUT   <= audio_nxt;
            AUDIO_VALID <= audio_valid_nxt;
            BUSY        <= busy_nxt;
            OVERRUN     <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_iq_fm_discriminator.sv
// Testbench for iq_fm_discriminator: scoreboard of expected phase steps
// computed from the driven I/Q pairs, checked when AUDIO_VALID strobes.
module tb_iq_fm_discriminator;

    localparam int unsigned IN_W  = 12;
    localparam int unsigned OUT_W = 12;
    localparam int          FS    = 4096;
    localparam int          LAT   = 16;
    localparam real         PI    = 3.14159265358979323846;

    localparam int PRIME = 0;
    localparam int PROC  = 1;
    localparam int DROP  = 2;

    typedef struct {
        string tag;
        int    expv;
        int    tol;
        int    issue;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic signed [IN_W-1:0]  i_in, q_in;
    logic signed [OUT_W-1:0] audio_out;
    logic                    audio_valid, busy, overrun;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   mp_i = 0;
    int   mp_q = 0;
    logic av_d = 1'b0;

    iq_fm_discriminator dut (
        .clk_in      (clk),
        .RST_n       (rst_n),
        .IN_VALID    (in_valid),
        .I_IN        (i_in),
        .Q_IN        (q_in),
        .AUDIO_OUT   (audio_out),
        .AUDIO_VALID (audio_valid),
        .BUSY        (busy),
        .OVERRUN     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare observed against expected; nonzero tol compares modulo full scale
    task automatic check(input string tag, input int obs, input int expv, input int tol = 0);
        int  d;
        bit  ok;
        n_cmp++;
        if (tol == 0) begin
            ok = (obs == expv);
        end else begin
            d = (((obs - expv) % FS) + FS) % FS;
            if (d >= FS / 2) d = d - FS;
            ok = (d <= tol) && (d >= -tol);
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    // Drive one pair for one cycle, starting at the current falling edge
    task automatic send(input string tag, input int i, input int q, input int mode, input int tol);
        exp_t e;
        int   re, im;
        real  ang;
        if (mode == PROC) begin
            re = i * mp_i + q * mp_q;
            im = q * mp_i - i * mp_q;
            e.tag   = tag;
            e.issue = cyc + 1;
            if (re == 0 && im == 0) begin
                e.expv = 0;
                e.tol  = 0;
            end else begin
                ang    = $atan2(real'(im), real'(re));
                e.expv = $rtoi($floor(ang / (2.0 * PI) * real'(FS) + 0.5));
                e.tol  = tol;
            end
            sb.push_back(e);
        end
        if (mode != DROP) begin
            mp_i = i;
            mp_q = q;
        end
        i_in     = IN_W'(i);
        q_in     = IN_W'(q);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 60 && sb.size() != 0; c++) @(negedge clk);
        check("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (audio_valid) begin
            check("strobe_gap", int'(av_d), 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_out"}, int'(audio_out), e.expv, e.tol);
                check({e.tag, "_lat"}, cyc - e.issue, LAT);
            end
        end
        av_d <= audio_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        i_in     = '0;
        q_in     = '0;
        repeat (3) @(negedge clk);
        check("rst_out", int'(audio_out), 0);
        check("rst_valid", int'(audio_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Priming sample produces nothing
        send("prime", 1000, 0, PRIME, 0);
        repeat (5) @(negedge clk);
        check("prime_busy", int'(busy), 0);

        // +pi/4 per step
        send("p45_a", 707, 707, PROC, 2);
        repeat (3) @(negedge clk);
        check("busy_mid", int'(busy), 1);
        repeat (16) @(negedge clk);
        send("p45_b", 0, 1000, PROC, 2);      gap(20);
        send("p45_c", -707, 707, PROC, 2);    gap(20);
        // -pi/2 per step
        send("m90_a", 707, 707, PROC, 2);     gap(20);
        send("m90_b", 707, -707, PROC, 2);    gap(20);
        send("m90_c", -707, -707, PROC, 2);   gap(20);
        // Arbitrary step, then identical samples
        send("arb", 500, -300, PROC, 2);      gap(20);
        send("same", 500, -300, PROC, 1);     gap(20);
        // pi per step wraps to the negative end
        send("pi_a", 800, 0, PROC, 2);        gap(20);
        send("pi_b", -800, 0, PROC, 1);
        wait_drain();

        // All-zero input yields exactly zero
        pulse_reset();
        send("zprime", 0, 0, PRIME, 0);       gap(20);
        send("zero", 0, 0, PROC, 0);
        wait_drain();

        // Overrun: dropped sample must not become prev
        pulse_reset();
        check("ovr_clear", int'(overrun), 0);
        send("oprime", 1000, 0, PRIME, 0);    gap(20);
        send("ov_b", 0, 1000, PROC, 2);
        repeat (3) @(negedge clk);
        send("ov_c", -1000, 0, DROP, 0);
        check("ovr_set", int'(overrun), 1);
        repeat (14) @(negedge clk);
        send("ov_d", 707, 707, PROC, 2);
        repeat (15) @(negedge clk);
        send("ov_e", -1000, 0, DROP, 0);      // lands on the DONE->IDLE edge
        send("ov_f", 1000, 0, PROC, 2);       // first slot that is accepted
        repeat (5) @(negedge clk);
        check("busy_f", int'(busy), 1);
        wait_drain();
        check("ovr_hold", int'(overrun), 1);

        // Reset during ROTATE k=5 aborts the sample
        send("abort", 0, 1000, PROC, 2);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_out", int'(audio_out), 0);
        check("abort_valid", int'(audio_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ovr", int'(overrun), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send("rprime", 1000, 0, PRIME, 0);
        repeat (5) @(negedge clk);
        check("rprime_busy", int'(busy), 0);
        repeat (14) @(negedge clk);
        send("post_rst", 707, -707, PROC, 2);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
